// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU operation classes and datapath mux select codes.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // States that own the shared memory and therefore run the wait counter
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class plus the
// instruction funct fields onto the datapath ALUControl code.
module alu_decoder
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_e               alu_op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7_5_i,
  input  logic                 op_5_i,
  output logic [ALUCTRL_W-1:0] alu_control_o
);

  logic [2:0] ctrl_s;

  always_comb begin
    ctrl_s = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: ctrl_s = ALU_ADD;
      ALUOP_SUB: ctrl_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type distinguishes sub; addi with imm[10]=1 stays add
          3'b000:  ctrl_s = (op_5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl_s = ALU_SLT;
          3'b110:  ctrl_s = ALU_OR;
          3'b111:  ctrl_s = ALU_AND;
          default: ctrl_s = ALU_ADD;
        endcase
      end
      default: ctrl_s = ALU_ADD;
    endcase
  end

  assign alu_control_o = ALUCTRL_W'(ctrl_s);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with memory wait-state timeout.
// Optional feature macro CU_ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int WAIT_W    = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MemTimeout,
  output logic                 IllegalInstr
);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                mem_state_s;
  logic                timeout_s;
  aluop_e              alu_op_s;
  logic                unused_funct7_s;

  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  assign mem_state_s = is_mem_state(state_q);
  assign timeout_s   = mem_state_s && !MemReady && (wait_q == WAIT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef CU_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (MemReady)       state_d = S_MEMWB;
        else if (timeout_s) state_d = S_FETCH;
        else                state_d = S_MEMREAD;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = (MemReady || timeout_s) ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Counter restarts on every state change and after a timeout re-FETCH
  always_comb begin
    if (timeout_s || (state_d != state_q)) begin
      wait_d = '0;
    end else if (mem_state_s && !MemReady) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
`ifdef CU_ILLEGAL_TRAP_EN
    illegal_d = illegal_q || (state_d == S_TRAP);
`else
    illegal_d = 1'b0;
`endif
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ImmSrc     = IMM_I;
    alu_op_s   = ALUOP_ADD;
    MemTimeout = 1'b0;
    if (!rst) begin
      MemTimeout = 1'b0;
    end else begin
      MemTimeout = timeout_s;
      case (state_q)
        S_FETCH: begin
          MemRead   = !timeout_s;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_B;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = Op[5] ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          MemRead = !timeout_s;
        end
        S_MEMWB: begin
          ResultSrc = RES_READDATA;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = !timeout_s;
        end
        S_EXECR: begin
          ALUSrcA  = SRCA_RD1;
          alu_op_s = ALUOP_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA  = SRCA_RD1;
          ALUSrcB  = SRCB_IMM;
          alu_op_s = ALUOP_FUNCT;
        end
        S_ALUWB:  RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA  = SRCA_RD1;
          alu_op_s = ALUOP_SUB;
          case (funct3)
            3'b000:  PCWrite = Zero;
            3'b001:  PCWrite = !Zero;
            default: PCWrite = 1'b0;
          endcase
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        S_TRAP:   PCWrite = 1'b0;
        default:  PCWrite = 1'b0;
      endcase
    end
  end

  assign IllegalInstr = rst && illegal_q;

  alu_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_decoder (
    .alu_op_i     (alu_op_s),
    .funct3_i     (funct3),
    .funct7_5_i   (funct7[5]),
    .op_5_i       (Op[5]),
    .alu_control_o(ALUControl)
  );

endmodule
